// File: rtl/div_pkg.sv
// Shared definitions for the shared-divider controller: state encoding,
// datapath width and the error-counter saturation helper.
package div_pkg;

    localparam int         DIV_W   = 16;
    localparam logic [7:0] ERR_SAT = 8'hFF;

    // Controller states; IDLE must stay the all-zero code so busy is simply state != IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Increment that sticks at ERR_SAT instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == ERR_SAT) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer, wrapping from NREQ-1 back to 0. Purely combinational.
module div_rr_arb #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic             o_any
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    // Scan the requests starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one combinational unsigned divider among NREQ requesters.
// Operands are latched on accept and held for SETTLE cycles (the divider is a
// multicycle path) before the quotient is registered and returned one-hot.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = DIV_W,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_num,
    input  logic [NREQ*WIDTH-1:0] req_den,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_quot,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_quot;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic [NREQ-1:0]  w_grant;
    logic             w_any;
    logic [PTR_W-1:0] w_win_idx;
    logic [WIDTH-1:0] w_sel_num;
    logic [WIDTH-1:0] w_sel_den;
    logic [WIDTH-1:0] w_div_q;
    logic [NREQ-1:0]  w_owner_oh;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_accept;
    logic             w_hs;
    logic             w_calc_done;

    div_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Encode the winner and mux its operands onto the accept path.
    always_comb begin
        w_win_idx = '0;
        w_sel_num = '0;
        w_sel_den = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx = PTR_W'(i);
                w_sel_num = req_num[i*WIDTH +: WIDTH];
                w_sel_den = req_den[i*WIDTH +: WIDTH];
            end
        end
    end

    // The shared divider sees only the latched operands, so its inputs are
    // stable for the whole CALC window.
    assign w_div_q     = r_num / r_den;
    assign w_owner_oh  = NREQ'(1) << r_owner;
    assign w_ptr_nxt   = (r_owner == PTR_W'(NREQ-1)) ? '0 : r_owner + PTR_W'(1);
    assign w_calc_done = (r_state == S_CALC) && (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state always uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the handshake outputs that depend on state.
    always_comb begin
        // NOTE: every output of this block is defaulted first; a path that
        // forgot one would otherwise infer a latch.
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        w_accept    = 1'b0;
        w_hs        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req_ready = w_grant;
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_sel_den == '0) ? S_RESP : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = w_owner_oh;
                if (rsp_ready[r_owner]) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, settle counter, quotient/error registers and rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand registers are reset along with the outputs; there
            // is no storage array here, so clearing everything is cheap and keeps
            // post-reset values deterministic.
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_num     <= '0;
            r_den     <= '0;
            r_quot    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_num   <= w_sel_num;
                r_den   <= w_sel_den;
                r_owner <= w_win_idx;
                r_cnt   <= CNT_W'(SETTLE - 1);
                if (w_sel_den == '0) begin
                    r_quot    <= '1;
                    r_err     <= 1'b1;
                    r_err_cnt <= sat_inc(r_err_cnt);
                end
            end
            if (w_calc_done) begin
                r_quot <= w_div_q;
                r_err  <= 1'b0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_hs) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign rsp_quot = r_quot;
    assign rsp_err  = r_err;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: a request-side model predicts grants
// and pushes expected responses; a response monitor pops and compares them.
module tb_div_share_ctrl;

    localparam int NREQ   = 4;
    localparam int W      = 16;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_num = '0;
    logic [NREQ*W-1:0] req_den = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [W-1:0]      rsp_quot;
    logic              rsp_err;
    logic              busy;
    logic [7:0]        err_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    div_share_ctrl #(.NREQ(NREQ), .WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_num   (req_num),
        .req_den   (req_den),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_quot  (rsp_quot),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         owner;
        logic [W-1:0] quot;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];

    // Model state: request side owns busy/ptr/err count, response side owns release.
    int m_busy        = 0;
    int m_ptr         = 0;
    int m_err_cnt     = 0;
    int m_acc_cyc     = -1;
    int m_release_cyc = -1;
    int m_next_ptr    = 0;
    int m_seen        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First valid requester at or after p, wrapping; -1 if none.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Request side: predict grant, push expected response on each accept.
    always @(negedge clk) begin
        int   w;
        exp_t e;
        logic [W-1:0] n;
        logic [W-1:0] d;
        if (!rst_n) begin
            m_busy    = 0;
            m_ptr     = 0;
            m_err_cnt = 0;
        end else begin
            if (m_busy != 0 && m_release_cyc > m_acc_cyc && m_release_cyc < cyc) begin
                m_busy = 0;
                m_ptr  = m_next_ptr;
            end
            check("busy", {31'd0, busy}, m_busy);
            check("err_cnt", {24'd0, err_cnt}, m_err_cnt);
            if (m_busy == 0) begin
                w = rr_pick(req_valid, m_ptr);
                check("req_ready", {28'd0, req_ready}, (w >= 0) ? (32'd1 << w) : 32'd0);
                if (w >= 0) begin
                    n = req_num[w*W +: W];
                    d = req_den[w*W +: W];
                    e.owner = w;
                    if (d == 0) begin
                        e.quot = 16'hFFFF;
                        e.err  = 1'b1;
                        e.due  = cyc + 1;
                        if (m_err_cnt < 255) m_err_cnt++;
                    end else begin
                        e.quot = n / d;
                        e.err  = 1'b0;
                        e.due  = cyc + SETTLE + 1;
                    end
                    sb.push_back(e);
                    m_busy    = 1;
                    m_acc_cyc = cyc;
                end
            end else begin
                check("req_ready_busy", {28'd0, req_ready}, 32'd0);
            end
        end
    end

    // Response monitor: compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_seen = 0;
        end else if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb[0];
                check("rsp_valid", {28'd0, rsp_valid}, 32'd1 << e.owner);
                check("rsp_quot", {16'd0, rsp_quot}, {16'd0, e.quot});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                if (m_seen == 0) check("rsp_latency", cyc, e.due);
                m_seen = 1;
                if (rsp_ready[e.owner]) begin
                    void'(sb.pop_front());
                    m_seen        = 0;
                    m_release_cyc = cyc;
                    m_next_ptr    = (e.owner + 1) % NREQ;
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            check("rsp_latency", cyc, sb[0].due);
            m_next_ptr    = (sb[0].owner + 1) % NREQ;
            m_release_cyc = cyc;
            m_seen        = 0;
            void'(sb.pop_front());
        end
    end

    function automatic logic [W-1:0] rand_num();
        int r = $urandom_range(0, 99);
        if (r < 10) return 16'hFFFF;
        if (r < 20) return 16'($urandom_range(0, 15));
        return 16'($urandom);
    endfunction

    function automatic logic [W-1:0] rand_den(input int zpct);
        int r = $urandom_range(0, 99);
        if (r < zpct)      return '0;
        if (r < zpct + 10) return 16'd1;
        if (r < zpct + 40) return 16'($urandom_range(2, 255));
        return 16'($urandom_range(1, 65535));
    endfunction

    // One request from idx; waits for grant and response, returns what was seen.
    task automatic single(input int idx, input logic [W-1:0] num, input logic [W-1:0] den,
                          output logic [NREQ-1:0] o_vld, output logic [W-1:0] o_q,
                          output logic o_e);
        int got = 0;
        o_vld = '0; o_q = '0; o_e = 1'b0;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_num[idx*W +: W] = num;
        req_den[idx*W +: W] = den;
        for (int t = 0; t < 50 && got == 0; t++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1;
        end
        if (got == 0) check("grant_wait", {28'd0, req_ready}, 32'd1 << idx);
        @(posedge clk); #1;
        req_valid = '0;
        got = 0;
        for (int t = 0; t < 50 && got == 0; t++) begin
            if (rsp_valid != '0) got = 1;
            else @(negedge clk);
        end
        if (got == 0) check("rsp_wait", {28'd0, rsp_valid}, 32'd1 << idx);
        o_vld = rsp_valid; o_q = rsp_quot; o_e = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int ncyc, input int zpct, input int rdy_pct);
        logic [NREQ-1:0] g;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        req_valid[i] = 1'b1;
                        req_num[i*W +: W] = rand_num();
                        req_den[i*W +: W] = rand_den(zpct);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req_valid[i] = 1'b0;
                end
                rsp_ready[i] = ($urandom_range(0, 99) < rdy_pct);
            end
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_queue", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NREQ-1:0] vld;
        logic [W-1:0]    q;
        logic            e;
        int              ord[5];
        int              exp_ord[5];
        int              n_ord;
        int              got;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_rsp_quot", {16'd0, rsp_quot}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = '1;
        repeat (2) @(posedge clk); #1;

        // Single op: 100/7 on requester 0.
        single(0, 16'd100, 16'd7, vld, q, e);
        check("single_vld", {28'd0, vld}, 32'h1);
        check("single_quot", {16'd0, q}, 32'd14);
        check("single_err", {31'd0, e}, 32'd0);

        // Divide by zero on requester 2.
        single(2, 16'd5, 16'd0, vld, q, e);
        check("dz_vld", {28'd0, vld}, 32'h4);
        check("dz_quot", {16'd0, q}, 32'hFFFF);
        check("dz_err", {31'd0, e}, 32'd1);
        check("dz_err_cnt", {24'd0, err_cnt}, 32'd1);

        // Reset in the middle of CALC drops the op and rewinds the pointer.
        req_valid = 4'b1000;
        req_num[3*W +: W] = 16'd1000;
        req_den[3*W +: W] = 16'd3;
        got = 0;
        for (int t = 0; t < 50 && got == 0; t++) begin
            @(negedge clk);
            if (req_ready[3]) got = 1;
        end
        if (got == 0) check("mid_grant_wait", {28'd0, req_ready}, 32'h8);
        @(posedge clk); #1;
        req_valid = '0;
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_quot", {16'd0, rsp_quot}, 32'd0);
        check("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round-robin: all four requesting 65535/1 continuously.
        exp_ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) ord[i] = -1;
        for (int i = 0; i < NREQ; i++) begin
            req_num[i*W +: W] = 16'hFFFF;
            req_den[i*W +: W] = 16'd1;
        end
        req_valid = '1;
        n_ord = 0;
        for (int t = 0; t < 100 && n_ord < 5; t++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    ord[n_ord] = i;
                    n_ord++;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 5; i++) check("rr_order", ord[i], exp_ord[i]);
        drain();

        // Backpressure on requester 1 while requester 0 keeps asking.
        rsp_ready = 4'b1101;
        req_num[1*W +: W] = 16'd50000;
        req_den[1*W +: W] = 16'd123;
        req_num[0*W +: W] = 16'd9;
        req_den[0*W +: W] = 16'd2;
        req_valid = 4'b0011;
        got = 0;
        for (int t = 0; t < 50 && got == 0; t++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1;
        end
        if (got == 0) check("bp_grant_wait", {28'd0, req_ready}, 32'h2);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        got = 0;
        for (int t = 0; t < 20 && got == 0; t++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1;
        end
        for (int t = 0; t < 10; t++) begin
            check("bp_rsp_valid", {28'd0, rsp_valid}, 32'h2);
            check("bp_quot", {16'd0, rsp_quot}, 32'd406);
            check("bp_err", {31'd0, rsp_err}, 32'd0);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = '1;
        got = 0;
        for (int t = 0; t < 50 && got == 0; t++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        if (got == 0) check("bp_grant0_wait", {28'd0, req_ready}, 32'h1);
        @(posedge clk); #1;
        drain();

        // Randomized traffic with mixed backpressure and zero denominators.
        run_random(1500, 10, 70);
        run_random(800, 30, 100);
        run_random(400, 5, 30);
        drain();

        // Saturation of the divide-by-zero counter.
        for (int k = 0; k < 300; k++) begin
            single(k % NREQ, 16'(k), 16'd0, vld, q, e);
        end
        drain();
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
